roll_over_generator: RTL and testbench

Programmable prescaler that turns the system clock into single-cycle rollover pulses. It sits directly upstream of the clock-toggle stage: `o_roll_over` drives that stage's `i_roll_over` input. The toggle stage therefore emits a square wave with period 2·N system cycles. The division factor N is reloadable at runtime, and changes take effect only on a period boundary, so the downstream clock never sees a truncated half-period.

---
 rtl/clock_pkg.sv | 18 +
 rtl/roll_over_generator.sv | 125 ++++++++++++
 tb/tb_roll_over_generator.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types for the clock generation chain. Both the rollover prescaler
// and the clock-toggle stage use them, so the state encoding and the divide
// width stay consistent across the chain.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int CLK_DIV_WIDTH = 16;

    typedef logic [CLK_DIV_WIDTH-1:0] divide_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rog_state_t;

endpackage : clock_pkg

// File: rtl/roll_over_generator.sv
// -----------------------------------------------------------------------------
// roll_over_generator
// Programmable prescaler. It emits a single-cycle rollover pulse every P
// enabled system cycles, where P = max(active divide, 1). The downstream
// toggle stage turns these pulses into a square wave with period 2*P.
// A new divide value can be loaded at runtime. It takes effect only on a
// period boundary, or immediately while idle, so the toggle stage never
// sees a truncated half-period.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       count enable; low freezes the counter (FSM -> IDLE)
//   i_load         one-cycle strobe capturing i_divide
//   i_divide       requested divide value N (0 behaves as 1)
//   o_roll_over    registered pulse, one cycle per period
//   o_count        current counter value
//   o_load_pending a captured divide value waits for the next boundary
//   o_running      FSM is in RUN
// -----------------------------------------------------------------------------
module roll_over_generator
    import clock_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_DIVIDE = 50_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_divide,
    output logic             o_roll_over,
    output logic [WIDTH-1:0] o_count,
    output logic             o_load_pending,
    output logic             o_running
);

    localparam logic [WIDTH-1:0] RESET_DIVIDE = WIDTH'(DEFAULT_DIVIDE);

    // State registers.
    rog_state_t       state_q,         state_d;
    logic [WIDTH-1:0] count_q,         count_d;
    logic [WIDTH-1:0] active_q,        active_d;
    logic [WIDTH-1:0] pending_q,       pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             roll_over_q,     roll_over_d;

    // Terminal count P-1, with a zero divide treated as a divide of one.
    logic [WIDTH-1:0] terminal;
    logic             at_terminal;
    logic             idle_apply;

    always_comb begin
        terminal    = (active_q == '0) ? '0 : active_q - WIDTH'(1);
        // A greater-or-equal compare recovers at once if the divide was
        // shrunk below the current count.
        at_terminal = (count_q >= terminal);
        // A pending value waiting while idle is applied on the very next
        // edge, including the edge that leaves IDLE; that edge restarts the
        // period from zero instead of counting.
        idle_apply  = (state_q == IDLE) && pending_valid_q;
    end

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first,
        // so no path through the branches can infer a latch.
        state_d         = i_enable ? RUN : IDLE;
        count_d         = count_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        roll_over_d     = 1'b0;

        if (idle_apply) begin
            // A strobe on this same edge is the newest value and wins.
            active_d        = i_load ? i_divide : pending_q;
            pending_valid_d = 1'b0;
            count_d         = '0;
        end else if (i_enable && at_terminal) begin
            // Period boundary: wrap, pulse, and swap in any new divide.
            count_d     = '0;
            roll_over_d = 1'b1;
            if (i_load) begin
                active_d = i_divide;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else begin
            if (i_enable) begin
                count_d = count_q + WIDTH'(1);
            end
            if (i_load) begin
                pending_d       = i_divide;
                pending_valid_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            active_q        <= RESET_DIVIDE;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            roll_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            roll_over_q     <= roll_over_d;
        end
    end

    assign o_roll_over    = roll_over_q;
    assign o_count        = count_q;
    assign o_load_pending = pending_valid_q;
    assign o_running      = (state_q == RUN);

endmodule : roll_over_generator

// File: tb/tb_roll_over_generator.sv
// -----------------------------------------------------------------------------
// tb_roll_over_generator
// Self-checking bench for roll_over_generator: a directed vector table,
// hand-written corner sequences and randomized traffic, all compared
// against a behavioural model of the prescaler.
// -----------------------------------------------------------------------------
module tb_roll_over_generator;

    localparam int W   = 16;
    localparam int DEF = 5;

    logic         clk;
    logic         rst;
    logic         en;
    logic         ld;
    logic [W-1:0] div;
    logic         ro;
    logic [W-1:0] cnt;
    logic         pend;
    logic         run;

    int vectors;
    int miscompares;

    roll_over_generator #(.WIDTH(W), .DEFAULT_DIVIDE(DEF)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_load        (ld),
        .i_divide      (div),
        .o_roll_over   (ro),
        .o_count       (cnt),
        .o_load_pending(pend),
        .o_running     (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  m_cnt, m_div, m_pend;
    bit  m_pv, m_run, m_ro;

    task automatic model_reset();
        m_cnt = 0; m_div = DEF; m_pend = 0;
        m_pv = 0; m_run = 0; m_ro = 0;
    endtask

    // One rising edge with inputs (e, l, d).
    task automatic model_edge(input bit e, input bit l, input int d);
        int period;
        period = (m_div < 1) ? 1 : m_div;
        m_ro = 0;
        if (!m_run && m_pv) begin
            m_div = l ? d : m_pend;
            m_pv  = 0;
            m_cnt = 0;
        end else if (e && m_cnt >= period - 1) begin
            m_cnt = 0;
            m_ro  = 1;
            if (l)         m_div = d;
            else if (m_pv) m_div = m_pend;
            m_pv = 0;
        end else begin
            if (e) m_cnt = m_cnt + 1;
            if (l) begin m_pend = d; m_pv = 1; end
        end
        m_run = e;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        check("roll_over", int'(ro),   int'(m_ro));
        check("count",     int'(cnt),  m_cnt);
        check("pending",   int'(pend), int'(m_pv));
        check("running",   int'(run),  int'(m_run));
    endtask

    // Apply inputs, take one edge, then compare away from the edge.
    task automatic tick(input bit e, input bit l, input int d);
        en = e; ld = l; div = W'(d);
        @(posedge clk);
        model_edge(e, l, d);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0; ld = 1'b0; div = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit en;
        bit ld;
        int div;
        bit ro;
        int cnt;
        bit pend;
        bit run;
    } vec_t;

    vec_t table_v[$];

    // Watchdog: the bench never hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulse_edges[$];
        int saw_pend;

        vectors = 0; miscompares = 0;
        rst = 1'b1; en = 1'b0; ld = 1'b0; div = '0;
        model_reset();
        #2;
        check("rst_ro",   int'(ro),   0);
        check("rst_cnt",  int'(cnt),  0);
        check("rst_pend", int'(pend), 0);
        check("rst_run",  int'(run),  0);
        do_reset();

        // ---- table: load N=4 while idle, then run with enable held high ----
        //                en ld div  ro cnt pend run
        table_v.push_back('{0, 1, 4,  0, 0, 1, 0});
        table_v.push_back('{1, 0, 0,  0, 0, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 1, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 2, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 3, 0, 1});
        table_v.push_back('{1, 0, 0,  1, 0, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 1, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 2, 0, 1});
        table_v.push_back('{1, 0, 0,  0, 3, 0, 1});
        table_v.push_back('{1, 0, 0,  1, 0, 0, 1});
        table_v.push_back('{0, 0, 0,  0, 0, 0, 0});
        foreach (table_v[i]) begin
            tick(table_v[i].en, table_v[i].ld, table_v[i].div);
            check("tbl_ro",   int'(ro),   int'(table_v[i].ro));
            check("tbl_cnt",  int'(cnt),  table_v[i].cnt);
            check("tbl_pend", int'(pend), int'(table_v[i].pend));
            check("tbl_run",  int'(run),  int'(table_v[i].run));
        end

        // ---- power-on latency with default divide: pulses after edges 5,10,15 ----
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            tick(1, 0, 0);
            if (ro) pulse_edges.push_back(k);
        end
        check("def_npulse", pulse_edges.size(), 3);
        if (pulse_edges.size() == 3) begin
            check("def_p0", pulse_edges[0], 5);
            check("def_p1", pulse_edges[1], 10);
            check("def_p2", pulse_edges[2], 15);
        end

        // ---- load 2 at count=1 while N=5 ----
        do_reset();
        tick(1, 0, 0);                          // count 1
        check("ld2_cnt1", int'(cnt), 1);
        tick(1, 1, 2);                          // captured, count 2
        check("ld2_pend", int'(pend), 1);
        tick(1, 0, 0); tick(1, 0, 0);           // counts 3, 4
        check("ld2_pend_hold", int'(pend), 1);
        tick(1, 0, 0);                          // boundary 4->0 applies
        check("ld2_apply_ro",   int'(ro),   1);
        check("ld2_apply_pend", int'(pend), 0);
        tick(1, 0, 0);
        check("ld2_gap", int'(ro), 0);
        tick(1, 0, 0);
        check("ld2_next", int'(ro), 1);

        // ---- load 3 on the boundary edge itself ----
        saw_pend = 0;
        tick(1, 0, 0);                          // count 1 (period 2 terminal)
        tick(1, 1, 3);                          // boundary + load
        check("bnd_ro", int'(ro), 1);
        if (pend) saw_pend++;
        for (int k = 1; k <= 3; k++) begin
            tick(1, 0, 0);
            if (pend) saw_pend++;
            check("bnd_pulse", int'(ro), (k == 3) ? 1 : 0);
        end
        check("bnd_never_pend", saw_pend, 0);

        // ---- N=0 and N=1: pulse every enabled cycle, count stays 0 ----
        for (int n = 0; n <= 1; n++) begin
            tick(0, 1, n);
            tick(1, 0, 0);                      // idle apply, count restarts
            for (int k = 0; k < 4; k++) begin
                tick(1, 0, 0);
                check("n01_ro",  int'(ro),  1);
                check("n01_cnt", int'(cnt), 0);
            end
        end

        // ---- disable at count=2 with N=6 for 5 cycles ----
        tick(0, 1, 6);
        tick(1, 0, 0);                          // apply, count 0
        tick(1, 0, 0); tick(1, 0, 0);           // count 2
        check("dis_cnt2", int'(cnt), 2);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0);
            check("dis_hold", int'(cnt), 2);
            check("dis_ro",   int'(ro),  0);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1, 0, 0);
            check("dis_resume", int'(ro), (k == 4) ? 1 : 0);
        end

        // ---- async reset mid-period with a load pending ----
        tick(1, 0, 0); tick(1, 1, 3);
        check("ar_pend_before", int'(pend), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_ro",   int'(ro),   0);
        check("ar_cnt",  int'(cnt),  0);
        check("ar_pend", int'(pend), 0);
        check("ar_run",  int'(run),  0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= DEF; k++) begin
            tick(1, 0, 0);
            check("ar_default", int'(ro), (k == DEF) ? 1 : 0);
        end

        // ---- randomized traffic against the model ----
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit e, l;
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 11) == 0);
            tick(e, l, $urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                #1 check("rnd_rst_cnt", int'(cnt), 0);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_roll_over_generator
